// File: rtl/lock_pkg.sv
// Shared types and helpers for the keypad input arbiter in front of digital_lock.
package lock_pkg;

    // Width of one keypad digit as seen by digital_lock.key_in.
    localparam int KEY_W = 4;

    // Arbiter session states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ABORT  = 2'd2,
        GAP    = 2'd3
    } arb_state_t;

    // Bits needed to index n items; never less than 1 so a 1-wide index still exists.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lock_rr_picker.sv
// Combinational round-robin finder: returns the first set req bit at or after rr_ptr, wrapping.
module lock_rr_picker
    import lock_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] winner,
    output logic             valid
);

    logic [IDX_W-1:0] cand_idx [N_REQ];
    logic [N_REQ-1:0] hit;

    // Candidate gi is the requester gi positions after the pointer, modulo N_REQ.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            assign sum          = {1'b0, rr_ptr} + (IDX_W+1)'(gi);
            assign cand_idx[gi] = (sum >= (IDX_W+1)'(N_REQ)) ? IDX_W'(sum - (IDX_W+1)'(N_REQ))
                                                             : sum[IDX_W-1:0];
            assign hit[gi]      = req[cand_idx[gi]];
        end
    endgenerate

    // Lowest candidate position wins; scanning downward lets the nearest one overwrite the rest.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                winner = cand_idx[k];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lock_input_arbiter.sv
// Shares the digital_lock keypad port between N_REQ requesters, one whole entry session
// at a time, round-robin. Optional inactivity timeout is built when LOCK_ARB_TIMEOUT_EN
// is defined; otherwise timeout_abort is tied low and no idle counter exists.
module lock_input_arbiter
    import lock_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int GAP_CYC     = 2,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       key_valid,
    input  logic [KEY_W*N_REQ-1:0] key_code,
    input  logic [N_REQ-1:0]       enter_req,
    input  logic [N_REQ-1:0]       clear_req,
    input  logic                   system_locked,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy,
    output logic [KEY_W-1:0]       lock_key_in,
    output logic                   lock_key_press,
    output logic                   lock_enter,
    output logic                   lock_clear,
    output logic                   session_done,
    output logic                   timeout_abort
);

    localparam int IDX_W = clog2(N_REQ);
    localparam int GAP_W = clog2(GAP_CYC);

    // Reject configurations the FSM cannot honour at elaboration time.
    generate
        if (N_REQ < 2 || N_REQ > 8 || GAP_CYC < 1 || TIMEOUT_CYC < 2) begin : g_bad_params
            $error("lock_input_arbiter: parameter out of range");
        end
    endgenerate

    arb_state_t       state_reg, state_next;
    logic [N_REQ-1:0] grant_reg, grant_next;
    logic [IDX_W-1:0] win_reg, win_next;
    logic [IDX_W-1:0] rr_ptr_reg, rr_ptr_next;
    logic             pend_enter_reg, pend_enter_next;
    logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
    logic [KEY_W-1:0] key_in_reg, key_in_next;
    logic             press_reg, press_next;
    logic             enter_reg, enter_next;
    logic             clear_reg, clear_next;
    logic             done_reg, done_next;
    logic             busy_reg;
`ifdef LOCK_ARB_TIMEOUT_EN
    localparam int IDLE_W = clog2(TIMEOUT_CYC);
    logic [IDLE_W-1:0] idle_cnt_reg, idle_cnt_next;
    logic              tmo_reg, tmo_next;
`endif

    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic             enter_gap;

    lock_rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr_reg),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    // Strobes of the current session owner; everyone else is ignored.
    logic             w_req, w_key, w_enter, w_clear;
    logic [KEY_W-1:0] w_code;
    assign w_req   = req[win_reg];
    assign w_key   = key_valid[win_reg];
    assign w_enter = enter_req[win_reg];
    assign w_clear = clear_req[win_reg];
    assign w_code  = key_code[win_reg*KEY_W +: KEY_W];

    // Next-state and registered-output computation for the session FSM.
    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        win_next        = win_reg;
        rr_ptr_next     = rr_ptr_reg;
        pend_enter_next = pend_enter_reg;
        gap_cnt_next    = gap_cnt_reg;
        key_in_next     = key_in_reg;
        press_next      = 1'b0;
        enter_next      = 1'b0;
        clear_next      = 1'b0;
        done_next       = 1'b0;
        enter_gap       = 1'b0;
`ifdef LOCK_ARB_TIMEOUT_EN
        idle_cnt_next   = idle_cnt_reg;
        tmo_next        = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (!system_locked && pick_valid) begin
                    state_next      = ACTIVE;
                    grant_next      = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    win_next        = pick_idx;
                    rr_ptr_next     = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    pend_enter_next = 1'b0;
`ifdef LOCK_ARB_TIMEOUT_EN
                    idle_cnt_next   = '0;
`endif
                end
            end
            ACTIVE: begin
                if (pend_enter_reg) begin
                    // Second half of a same-cycle digit+enter: the enter trails the digit.
                    enter_next = 1'b1;
                    enter_gap  = 1'b1;
                end else if (system_locked) begin
                    // Lockout: the lock manages its own state, so close silently.
                    enter_gap = 1'b1;
                end else if (w_clear) begin
                    clear_next = 1'b1;
                    enter_gap  = 1'b1;
                end else if (w_enter && w_key) begin
                    key_in_next     = w_code;
                    press_next      = 1'b1;
                    pend_enter_next = 1'b1;
                end else if (w_enter) begin
                    enter_next = 1'b1;
                    enter_gap  = 1'b1;
                end else if (!w_req) begin
                    // Abandoned session: flush partial digits from the lock.
                    state_next = ABORT;
                    clear_next = 1'b1;
                end else if (w_key) begin
                    key_in_next = w_code;
                    press_next  = 1'b1;
`ifdef LOCK_ARB_TIMEOUT_EN
                    idle_cnt_next = IDLE_W'(1);
                end else if (idle_cnt_reg == IDLE_W'(TIMEOUT_CYC - 1)) begin
                    state_next = ABORT;
                    clear_next = 1'b1;
                    tmo_next   = 1'b1;
                end else begin
                    idle_cnt_next = idle_cnt_reg + 1'b1;
`endif
                end
            end
            ABORT: begin
                enter_gap = 1'b1;
            end
            GAP: begin
                if (gap_cnt_reg == GAP_W'(GAP_CYC - 1)) begin
                    state_next = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase

        // Common session close: drop grant, start the gap, flag completion.
        if (enter_gap) begin
            state_next      = GAP;
            grant_next      = '0;
            gap_cnt_next    = '0;
            pend_enter_next = 1'b0;
            done_next       = 1'b1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            win_reg        <= '0;
            rr_ptr_reg     <= '0;
            pend_enter_reg <= 1'b0;
            gap_cnt_reg    <= '0;
            key_in_reg     <= '0;
            press_reg      <= 1'b0;
            enter_reg      <= 1'b0;
            clear_reg      <= 1'b0;
            done_reg       <= 1'b0;
            busy_reg       <= 1'b0;
`ifdef LOCK_ARB_TIMEOUT_EN
            idle_cnt_reg   <= '0;
            tmo_reg        <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            win_reg        <= win_next;
            rr_ptr_reg     <= rr_ptr_next;
            pend_enter_reg <= pend_enter_next;
            gap_cnt_reg    <= gap_cnt_next;
            key_in_reg     <= key_in_next;
            press_reg      <= press_next;
            enter_reg      <= enter_next;
            clear_reg      <= clear_next;
            done_reg       <= done_next;
            busy_reg       <= (state_next != IDLE);
`ifdef LOCK_ARB_TIMEOUT_EN
            idle_cnt_reg   <= idle_cnt_next;
            tmo_reg        <= tmo_next;
`endif
        end
    end

    assign grant          = grant_reg;
    assign busy           = busy_reg;
    assign lock_key_in    = key_in_reg;
    assign lock_key_press = press_reg;
    assign lock_enter     = enter_reg;
    assign lock_clear     = clear_reg;
    assign session_done   = done_reg;
`ifdef LOCK_ARB_TIMEOUT_EN
    assign timeout_abort  = tmo_reg;
`else
    assign timeout_abort  = 1'b0;
`endif

endmodule

// File: tb/tb_lock_input_arbiter.sv
// Directed bench for lock_input_arbiter (2 requesters, 2-cycle gap, timeout limit 8).
module tb_lock_input_arbiter;

    localparam int N_REQ       = 2;
    localparam int GAP_CYC     = 2;
    localparam int TIMEOUT_CYC = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic [N_REQ-1:0]   req;
    logic [N_REQ-1:0]   key_valid;
    logic [4*N_REQ-1:0] key_code;
    logic [N_REQ-1:0]   enter_req;
    logic [N_REQ-1:0]   clear_req;
    logic               system_locked;
    logic [N_REQ-1:0]   grant;
    logic               busy;
    logic [3:0]         lock_key_in;
    logic               lock_key_press;
    logic               lock_enter;
    logic               lock_clear;
    logic               session_done;
    logic               timeout_abort;

    int n_checks = 0;
    int n_fail   = 0;
    int excl_viol = 0;

    lock_input_arbiter #(
        .N_REQ       (N_REQ),
        .GAP_CYC     (GAP_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .enter_req      (enter_req),
        .clear_req      (clear_req),
        .system_locked  (system_locked),
        .grant          (grant),
        .busy           (busy),
        .lock_key_in    (lock_key_in),
        .lock_key_press (lock_key_press),
        .lock_enter     (lock_enter),
        .lock_clear     (lock_clear),
        .session_done   (session_done),
        .timeout_abort  (timeout_abort)
    );

    always #5 clk = ~clk;

    // Count cycles where more than one lock pulse is high at once.
    always @(negedge clk) begin
        if ((int'(lock_key_press) + int'(lock_enter) + int'(lock_clear)) > 1) begin
            excl_viol <= excl_viol + 1;
        end
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        key_valid = '0;
        key_code  = '0;
        enter_req = '0;
        clear_req = '0;
    endtask

    task automatic pulses(input string tag, input logic p, input logic e, input logic c, input logic d);
        check({tag, ".press"}, lock_key_press, p);
        check({tag, ".enter"}, lock_enter, e);
        check({tag, ".clear"}, lock_clear, c);
        check({tag, ".done"},  session_done, d);
    endtask

    // One digit strobe from requester r; the digit must reach the lock one cycle later.
    task automatic send_key(input int r, input logic [3:0] code, input string tag);
        key_valid[r]       = 1'b1;
        key_code[r*4 +: 4] = code;
        tick();
        quiet();
        check({tag, ".press"}, lock_key_press, 1'b1);
        check({tag, ".code"},  lock_key_in, code);
        $display("key r%0d code %0h -> lock_key_in %0h", r, code, lock_key_in);
    endtask

    // Close the session of requester r with enter or clear and check the closing pulse.
    task automatic end_session(input int r, input bit use_clear, input string tag);
        if (use_clear) clear_req[r] = 1'b1;
        else           enter_req[r] = 1'b1;
        tick();
        quiet();
        pulses(tag, 1'b0, !use_clear, use_clear, 1'b1);
        check({tag, ".grant"}, grant, 0);
        $display("session r%0d closed by %s", r, use_clear ? "clear" : "enter");
    endtask

    // From the first GAP cycle: two gap cycles, one IDLE cycle, then the next grant.
    task automatic next_grant(input logic [N_REQ-1:0] exp, input string tag);
        tick();
        tick();
        check({tag, ".idle_busy"}, busy, 1'b0);
        tick();
        check({tag, ".grant"}, grant, exp);
        $display("grant -> %b", grant);
    endtask

    initial begin
        reset = 1'b1;
        req = '0;
        system_locked = 1'b0;
        quiet();
        tick();
        tick();
        check("rst.grant", grant, 0);
        check("rst.busy", busy, 0);
        check("rst.key_in", lock_key_in, 0);
        check("rst.tmo", timeout_abort, 0);
        pulses("rst", 0, 0, 0, 0);

        // T1: single requester, four digits then enter.
        reset = 1'b0;
        req = 2'b01;
        tick();
        check("t1.grant", grant, 2'b01);
        check("t1.busy", busy, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            send_key(0, 4'(i), "t1.key");
        end
        end_session(0, 1'b0, "t1.enter");
        check("t1.gap_busy", busy, 1'b1);
        req = 2'b00;
        tick();
        pulses("t1.gap2", 0, 0, 0, 0);
        check("t1.gap2_busy", busy, 1'b1);
        tick();
        check("t1.idle_busy", busy, 1'b0);

        // T2: both request together after reset; alternate 0,1,0,1.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = 2'b11;
        tick();
        check("t2.s0.grant", grant, 2'b01);
        key_valid[1] = 1'b1;
        key_code[7:4] = 4'h9;
        tick();
        quiet();
        check("t2.foreign1", lock_key_press, 1'b0);
        end_session(0, 1'b0, "t2.s0");
        next_grant(2'b10, "t2.s1");
        key_valid[0] = 1'b1;
        key_code[3:0] = 4'h5;
        tick();
        quiet();
        check("t2.foreign0", lock_key_press, 1'b0);
        end_session(1, 1'b1, "t2.s1");
        next_grant(2'b01, "t2.s2");
        end_session(0, 1'b0, "t2.s2");
        next_grant(2'b10, "t2.s3");

        // T3: digit 7 with enter in one cycle; then clear with enter.
        key_valid[1] = 1'b1;
        key_code[7:4] = 4'h7;
        enter_req[1] = 1'b1;
        tick();
        quiet();
        pulses("t3.kd", 1, 0, 0, 0);
        check("t3.kd.code", lock_key_in, 4'h7);
        check("t3.kd.grant", grant, 2'b10);
        tick();
        pulses("t3.late_enter", 0, 1, 0, 1);
        check("t3.late_grant", grant, 0);
        next_grant(2'b01, "t3.s0");
        clear_req[0] = 1'b1;
        enter_req[0] = 1'b1;
        tick();
        quiet();
        pulses("t3.ce", 0, 0, 1, 1);
        req = 2'b01;
        tick();
        pulses("t3.no_enter", 0, 0, 0, 0);
        tick();
        tick();
        check("t4.grant", grant, 2'b01);

        // T4: two digits then requester drops -> flush with clear.
        send_key(0, 4'h5, "t4.key");
        send_key(0, 4'h6, "t4.key");
        req = 2'b00;
        tick();
        pulses("t4.abort", 0, 0, 1, 0);
        check("t4.abort_tmo", timeout_abort, 0);
        tick();
        pulses("t4.gap", 0, 0, 0, 1);
        check("t4.gap_grant", grant, 0);
        check("t4.key_hold", lock_key_in, 4'h6);
        $display("session r0 aborted by req drop");

        // T5: lockout holds off the grant; unlock grants next cycle; lockout mid-session.
        system_locked = 1'b1;
        req = 2'b01;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t5.locked_grant", grant, 0);
        end
        system_locked = 1'b0;
        tick();
        check("t5.unlock_grant", grant, 2'b01);
        send_key(0, 4'h2, "t5.key");
        system_locked = 1'b1;
        key_valid[0] = 1'b1;
        key_code[3:0] = 4'h8;
        tick();
        quiet();
        pulses("t5.midlock", 0, 0, 0, 1);
        check("t5.midlock_grant", grant, 0);
        check("t5.midlock_key", lock_key_in, 4'h2);
        $display("session r0 closed by lockout");
        system_locked = 1'b0;
        req = 2'b00;
        tick();
        tick();

`ifdef LOCK_ARB_TIMEOUT_EN
        // T6: one digit then silence -> clear and timeout_abort 8 cycles after the digit.
        req = 2'b01;
        tick();
        check("t6.grant", grant, 2'b01);
        send_key(0, 4'hA, "t6.key");
        for (int i = 2; i <= 7; i++) begin
            tick();
            check("t6.wait_clear", lock_clear, 0);
            check("t6.wait_tmo", timeout_abort, 0);
        end
        tick();
        check("t6.clear", lock_clear, 1'b1);
        check("t6.tmo", timeout_abort, 1'b1);
        tick();
        check("t6.done", session_done, 1'b1);
        check("t6.grant_off", grant, 0);
        $display("session r0 closed by timeout");
        req = 2'b00;
`endif

        tick();
        check("excl.pulses", excl_viol, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
